controlador_multiciclo_param: RTL and testbench
===============================================

# controlador_multiciclo_param

Parametrised multicycle RISC-V (RV32I subset) control unit. It drives the shared-ALU, single-memory datapath: PC, PCBack, IR, MDR, A/B, ALUOut registers and their muxes. It extends the existing controller in three ways:
- wider instruction coverage: I-type ALU, LUI, AUIPC, JALR, all six branch conditions;
- a ready/valid-style memory wait handshake, so memory latency is variable;
- a sticky illegal-instruction trap.

## Interface
Parameters:
- ALUCTRL_W, default 4: ALU control width (minimum 4).
- SEL_W, default 3: width of every mux-select output.
- STATE_W, default 6: width of oState.
- EN_ITYPE, default 1: when 0, OP-IMM, LUI, AUIPC and JALR decode as illegal.

Ports:
- iCLK, input, 1: clock. All state changes on the rising edge.
- iReset, input, 1: synchronous, active-high reset.
- iInst, input, 32: IR contents, valid from DECODE onward.
- iMemReady, input, 1: memory has completed the current access this cycle.
- oEscrevePC, output, 1: unconditional PC write.
- oEscrevePCCondicional, output, 1: PC write if the datapath branch-taken flag is set.
- oEscrevePCBack, output, 1: latch the old PC into PCBack.
- oEscreveIR, output, 1: IR write.
- oEscreveMDR, output, 1: MDR write.
- oEscreveReg, output, 1: register-file write.
- oEscreveMem, output, 1: memory write request.
- oLeMem, output, 1: memory read request.
- oIouD, output, 1: memory address select. 0 = PC, 1 = ALUOut.
- oOrigAULA, output, SEL_W: ALU A select. 0 = A, 1 = PC, 2 = PCBack, 3 = zero.
- oOrigBULA, output, SEL_W: ALU B select. 0 = B, 1 = constant 4, 2 = immediate.
- oMemPraReg, output, SEL_W: write-back select. 0 = ALUOut, 1 = PC, 2 = MDR.
- oOrigPC, output, SEL_W: PC source. 0 = ALU result, 1 = ALUOut, 2 = ALU result & ~1.
- oULAControl, output, ALUCTRL_W: ALU operation code.
- oCondBranch, output, 3: funct3 passed to the comparator. Valid only in BRANCH; 0 otherwise.
- oIllegal, output, 1: sticky illegal-instruction flag.
- oState, output, STATE_W: current state encoding, for debug.

## Operation
- Moore FSM. Outputs are a function of the state register, plus combinational funct3/funct7 decode in RTYPE, ITYPE and BRANCH.
- Any output not listed for a state is 0. oULAControl defaults to ADD (0010).

State transitions:
- FETCH(0): oLeMem=1, oIouD=0. Stays in FETCH while iMemReady=0; goes to FETCH1 when iMemReady=1.
- FETCH1(1): oEscreveIR=1, oEscrevePC=1, oEscrevePCBack=1, A=PC, B=4, ADD, oOrigPC=0. Goes to DECODE.
- DECODE(2): A=PCBack, B=imm, ADD, which precomputes the branch/JAL target into ALUOut. Dispatches on opcode:
  - LOAD or STORE → ADDR
  - OP → RTYPE
  - OP-IMM → ITYPE
  - BRANCH → BRANCH
  - JAL → JAL
  - JALR → JALR
  - LUI → LUI
  - AUIPC → AUIPC
  - any other opcode → ILLEGAL
- ADDR(3): A=A, B=imm, ADD. Goes to LW on a load, SW on a store.
- LW(4): oLeMem=1, oIouD=1, oEscreveMDR=iMemReady. Waits while iMemReady=0, then goes to LW_WB.
- LW_WB(5): oEscreveReg=1, oMemPraReg=2. Goes to FETCH.
- SW(6): oEscreveMem=1, oIouD=1. Held while iMemReady=0, then goes to FETCH.
- RTYPE(7): A=A, B=B, op from funct3/funct7. Goes to ALUWB.
- ITYPE(8): A=A, B=imm, op from funct3 (funct7[5] applies only to SRAI). Goes to ALUWB.
- ALUWB(9): oEscreveReg=1, oMemPraReg=0. Goes to FETCH.
- BRANCH(10): A=A, B=B, SUB, oEscrevePCCondicional=1, oOrigPC=1, oCondBranch=funct3. Goes to FETCH.
- JAL(11): oEscreveReg=1, oMemPraReg=1, oEscrevePC=1, oOrigPC=1. Goes to FETCH.
- JALR(12): A=A, B=imm, ADD, oOrigPC=2, oEscrevePC=1, oEscreveReg=1, oMemPraReg=1. Goes to FETCH.
- LUI(13): A=zero, B=imm, ADD. Goes to ALUWB.
- AUIPC(14): A=PCBack, B=imm, ADD. Goes to ALUWB.
- ILLEGAL(15): all enables 0, oIllegal=1. The state is held until iReset.

ALU codes:
- AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLL 1000, SRL 1001, SRA 1010, SLTU 1011.
- The upper ALUCTRL_W-4 bits are zero.
- Any funct3/funct7 combination not in this list, in RTYPE or ITYPE, goes to ILLEGAL instead of ALUWB.

## Timing
- Reset: iReset=1 at a clock edge puts the FSM in FETCH.
  - Outputs after reset: oState=0, oLeMem=1, every other output 0 (oULAControl=0010).
  - Reset mid-access abandons the access; no write enable is asserted in the reset cycle's successor.
- Zero-wait latency in cycles:
  - R-type, I-type, LUI, AUIPC: 5
  - load: 6
  - store: 5
  - branch, JAL, JALR: 4
- Each cycle with iMemReady=0 in FETCH, LW or SW adds one cycle.
- iMemReady is ignored in every other state.
- Memory request outputs remain constant during wait cycles.
- iInst must be stable from DECODE until the return to FETCH.

## Structure
- Shared package `controlador_pkg` holds:
  - state encodings
  - RV32I opcode, funct3 and funct7 constants
  - ALU op codes
  - mux-select encodings
- One sub-module, `decod_ula`: combinational funct3/funct7 → {oULAControl, illegal}, with an R-type/I-type mode input.

## Test plan
- Reset, then iMemReady=1, add x3,x1,x2 (0x002081B3): oState sequence 0,1,2,7,9,0. oULAControl=0010 in RTYPE. oEscreveReg=1 only in state 9.
- lw x5,8(x1) (0x0080A283) with iMemReady held 0 for 3 cycles in LW: state 4 lasts 4 cycles, oEscreveMDR=1 only in the last. Total 9 cycles.
- sub (0x402081B3) → oULAControl=0110. srai (0x4020D193) → 1010. slt (0x0020A1B3) → 0111.
- beq (0x00208463): BRANCH has oEscrevePCCondicional=1, oCondBranch=000, oOrigPC=1. jalr x1,0(x2) (0x000100E7): oOrigPC=2, oMemPraReg=1.
- Opcode 0x7F: DECODE→15, then oIllegal=1 persists over 20 cycles. iReset → oState=0, oIllegal=0.
- EN_ITYPE=0 with lui (0x123452B7) → ILLEGAL. iReset asserted during the LW wait → next state FETCH, oEscreveReg never 1.

Source files
------------

// File: rtl/controlador_multiciclo_param_pkg.sv
// Shared definitions for the multicycle RV32I control unit: state encodings,
// opcode/funct constants, ALU operation codes and datapath mux selects.
package controlador_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_FETCH1  = 4'd1,
    ST_DECODE  = 4'd2,
    ST_ADDR    = 4'd3,
    ST_LW      = 4'd4,
    ST_LW_WB   = 4'd5,
    ST_SW      = 4'd6,
    ST_RTYPE   = 4'd7,
    ST_ITYPE   = 4'd8,
    ST_ALUWB   = 4'd9,
    ST_BRANCH  = 4'd10,
    ST_JAL     = 4'd11,
    ST_JALR    = 4'd12,
    ST_LUI     = 4'd13,
    ST_AUIPC   = 4'd14,
    ST_ILLEGAL = 4'd15
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;

  localparam logic [1:0] SELA_A      = 2'd0;
  localparam logic [1:0] SELA_PC     = 2'd1;
  localparam logic [1:0] SELA_PCBACK = 2'd2;
  localparam logic [1:0] SELA_ZERO   = 2'd3;

  localparam logic [1:0] SELB_B   = 2'd0;
  localparam logic [1:0] SELB_4   = 2'd1;
  localparam logic [1:0] SELB_IMM = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_PC     = 2'd1;
  localparam logic [1:0] WB_MDR    = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JALR   = 2'd2;

endpackage

// File: rtl/controlador_multiciclo_param_if.sv
// Instruction/memory handshake and datapath control bundle between the
// controller (master) and the datapath (slave).
interface controlador_multiciclo_param_if #(
  parameter int unsigned ALUCTRL_W = 4,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned STATE_W   = 6
);
  logic [31:0]          iInst;
  logic                 iMemReady;
  logic                 oEscrevePC;
  logic                 oEscrevePCCondicional;
  logic                 oEscrevePCBack;
  logic                 oEscreveIR;
  logic                 oEscreveMDR;
  logic                 oEscreveReg;
  logic                 oEscreveMem;
  logic                 oLeMem;
  logic                 oIouD;
  logic [SEL_W-1:0]     oOrigAULA;
  logic [SEL_W-1:0]     oOrigBULA;
  logic [SEL_W-1:0]     oMemPraReg;
  logic [SEL_W-1:0]     oOrigPC;
  logic [ALUCTRL_W-1:0] oULAControl;
  logic [2:0]           oCondBranch;
  logic                 oIllegal;
  logic [STATE_W-1:0]   oState;

  modport master (
    input  iInst, iMemReady,
    output oEscrevePC, oEscrevePCCondicional, oEscrevePCBack, oEscreveIR,
           oEscreveMDR, oEscreveReg, oEscreveMem, oLeMem, oIouD,
           oOrigAULA, oOrigBULA, oMemPraReg, oOrigPC, oULAControl,
           oCondBranch, oIllegal, oState
  );

  modport slave (
    output iInst, iMemReady,
    input  oEscrevePC, oEscrevePCCondicional, oEscrevePCBack, oEscreveIR,
           oEscreveMDR, oEscreveReg, oEscreveMem, oLeMem, oIouD,
           oOrigAULA, oOrigBULA, oMemPraReg, oOrigPC, oULAControl,
           oCondBranch, oIllegal, oState
  );
endinterface

// File: rtl/controlador_multiciclo_param_decod_ula.sv
// funct3/funct7 to ALU operation decode for OP and OP-IMM instructions,
// flagging encodings outside the supported RV32I set.
module decod_ula
  import controlador_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       itype_i,
  output logic [3:0] aluctrl_o,
  output logic       illegal_o
);
  logic base7;
  logic alt7;

  assign base7 = (funct7_i == F7_BASE);
  assign alt7  = (funct7_i == F7_ALT);

  // In I-type, funct7 bits are immediate bits except for the shift forms.
  always_comb begin
    aluctrl_o = ALU_ADD;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_ADD_SUB: begin
        if (itype_i || base7) aluctrl_o = ALU_ADD;
        else if (alt7)        aluctrl_o = ALU_SUB;
        else                  illegal_o = 1'b1;
      end
      F3_SLL: begin
        aluctrl_o = ALU_SLL;
        illegal_o = !base7;
      end
      F3_SLT: begin
        aluctrl_o = ALU_SLT;
        illegal_o = !itype_i && !base7;
      end
      F3_SLTU: begin
        aluctrl_o = ALU_SLTU;
        illegal_o = !itype_i && !base7;
      end
      F3_XOR: begin
        aluctrl_o = ALU_XOR;
        illegal_o = !itype_i && !base7;
      end
      F3_SR: begin
        if (base7)     aluctrl_o = ALU_SRL;
        else if (alt7) aluctrl_o = ALU_SRA;
        else           illegal_o = 1'b1;
      end
      F3_OR: begin
        aluctrl_o = ALU_OR;
        illegal_o = !itype_i && !base7;
      end
      default: begin
        aluctrl_o = ALU_AND;
        illegal_o = !itype_i && !base7;
      end
    endcase
  end
endmodule

// File: rtl/controlador_multiciclo_param.sv
// Multicycle RV32I control unit: Moore FSM driving the shared-ALU,
// single-memory datapath, with memory wait states and a sticky illegal trap.
module controlador_multiciclo_param
  import controlador_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 4,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned STATE_W   = 6,
  parameter int unsigned EN_ITYPE  = 1
) (
  input logic iCLK,
  input logic iReset,
  controlador_multiciclo_param_if.master ctrl_bus
);
  state_e     state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       mem_ready;
  logic       unused_inst_bits;
  logic [3:0] dec_op;
  logic       dec_illegal;
  logic       en_itype;

  logic       pc_w, pc_cond, pcback_w, ir_w, mdr_w, reg_w, mem_w, mem_r, iou_d;
  logic [1:0] orig_a, orig_b, mem2reg, orig_pc;
  logic [3:0] ula;
  logic [2:0] cond;

  assign opcode           = ctrl_bus.iInst[6:0];
  assign funct3           = ctrl_bus.iInst[14:12];
  assign funct7           = ctrl_bus.iInst[31:25];
  assign unused_inst_bits = ^{ctrl_bus.iInst[24:15], ctrl_bus.iInst[11:7]};
  assign mem_ready        = ctrl_bus.iMemReady;
  assign en_itype         = (EN_ITYPE != 0);

  decod_ula u_decod_ula (
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .itype_i   (state_q == ST_ITYPE),
    .aluctrl_o (dec_op),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge iCLK) begin
    if (iReset) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pc_w     = 1'b0;
    pc_cond  = 1'b0;
    pcback_w = 1'b0;
    ir_w     = 1'b0;
    mdr_w    = 1'b0;
    reg_w    = 1'b0;
    mem_w    = 1'b0;
    mem_r    = 1'b0;
    iou_d    = 1'b0;
    orig_a   = SELA_A;
    orig_b   = SELB_B;
    mem2reg  = WB_ALUOUT;
    orig_pc  = PCSRC_ALU;
    ula      = ALU_ADD;
    cond     = '0;
    case (state_q)
      ST_FETCH: begin
        mem_r = 1'b1;
        if (mem_ready) state_d = ST_FETCH1;
      end
      ST_FETCH1: begin
        ir_w     = 1'b1;
        pc_w     = 1'b1;
        pcback_w = 1'b1;
        orig_a   = SELA_PC;
        orig_b   = SELB_4;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        orig_a = SELA_PCBACK;
        orig_b = SELB_IMM;
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = ST_ADDR;
          OPC_OP:              state_d = ST_RTYPE;
          OPC_BRANCH:          state_d = ST_BRANCH;
          OPC_JAL:             state_d = ST_JAL;
          OPC_OP_IMM:          state_d = en_itype ? ST_ITYPE : ST_ILLEGAL;
          OPC_JALR:            state_d = en_itype ? ST_JALR  : ST_ILLEGAL;
          OPC_LUI:             state_d = en_itype ? ST_LUI   : ST_ILLEGAL;
          OPC_AUIPC:           state_d = en_itype ? ST_AUIPC : ST_ILLEGAL;
          default:             state_d = ST_ILLEGAL;
        endcase
      end
      ST_ADDR: begin
        orig_b  = SELB_IMM;
        state_d = (opcode == OPC_STORE) ? ST_SW : ST_LW;
      end
      ST_LW: begin
        mem_r = 1'b1;
        iou_d = 1'b1;
        mdr_w = mem_ready;
        if (mem_ready) state_d = ST_LW_WB;
      end
      ST_LW_WB: begin
        reg_w   = 1'b1;
        mem2reg = WB_MDR;
        state_d = ST_FETCH;
      end
      ST_SW: begin
        mem_w = 1'b1;
        iou_d = 1'b1;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_RTYPE: begin
        ula     = dec_op;
        state_d = dec_illegal ? ST_ILLEGAL : ST_ALUWB;
      end
      ST_ITYPE: begin
        orig_b  = SELB_IMM;
        ula     = dec_op;
        state_d = dec_illegal ? ST_ILLEGAL : ST_ALUWB;
      end
      ST_ALUWB: begin
        reg_w   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        ula     = ALU_SUB;
        pc_cond = 1'b1;
        orig_pc = PCSRC_ALUOUT;
        cond    = funct3;
        state_d = ST_FETCH;
      end
      ST_JAL: begin
        reg_w   = 1'b1;
        mem2reg = WB_PC;
        pc_w    = 1'b1;
        orig_pc = PCSRC_ALUOUT;
        state_d = ST_FETCH;
      end
      ST_JALR: begin
        orig_b  = SELB_IMM;
        orig_pc = PCSRC_JALR;
        pc_w    = 1'b1;
        reg_w   = 1'b1;
        mem2reg = WB_PC;
        state_d = ST_FETCH;
      end
      ST_LUI: begin
        orig_a  = SELA_ZERO;
        orig_b  = SELB_IMM;
        state_d = ST_ALUWB;
      end
      ST_AUIPC: begin
        orig_a  = SELA_PCBACK;
        orig_b  = SELB_IMM;
        state_d = ST_ALUWB;
      end
      ST_ILLEGAL: state_d = ST_ILLEGAL;
      default:    state_d = ST_FETCH;
    endcase
  end

  assign ctrl_bus.oEscrevePC            = pc_w;
  assign ctrl_bus.oEscrevePCCondicional = pc_cond;
  assign ctrl_bus.oEscrevePCBack        = pcback_w;
  assign ctrl_bus.oEscreveIR            = ir_w;
  assign ctrl_bus.oEscreveMDR           = mdr_w;
  assign ctrl_bus.oEscreveReg           = reg_w;
  assign ctrl_bus.oEscreveMem           = mem_w;
  assign ctrl_bus.oLeMem                = mem_r;
  assign ctrl_bus.oIouD                 = iou_d;
  assign ctrl_bus.oOrigAULA             = SEL_W'(orig_a);
  assign ctrl_bus.oOrigBULA             = SEL_W'(orig_b);
  assign ctrl_bus.oMemPraReg            = SEL_W'(mem2reg);
  assign ctrl_bus.oOrigPC               = SEL_W'(orig_pc);
  assign ctrl_bus.oULAControl           = ALUCTRL_W'(ula);
  assign ctrl_bus.oCondBranch           = cond;
  assign ctrl_bus.oIllegal              = (state_q == ST_ILLEGAL);
  assign ctrl_bus.oState                = STATE_W'(state_q);
endmodule

// File: tb/tb_controlador_multiciclo_param.sv
// Directed self-checking bench for the multicycle control unit; a second
// instance has the I-type group disabled.
module tb_controlador_multiciclo_param;
  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  controlador_multiciclo_param_if #(.ALUCTRL_W(4), .SEL_W(3), .STATE_W(6)) if1 ();
  controlador_multiciclo_param_if #(.ALUCTRL_W(4), .SEL_W(3), .STATE_W(6)) if2 ();

  controlador_multiciclo_param #(.ALUCTRL_W(4), .SEL_W(3), .STATE_W(6), .EN_ITYPE(1)) dut1 (
    .iCLK(clk), .iReset(rst1), .ctrl_bus(if1)
  );
  controlador_multiciclo_param #(.ALUCTRL_W(4), .SEL_W(3), .STATE_W(6), .EN_ITYPE(0)) dut2 (
    .iCLK(clk), .iReset(rst2), .ctrl_bus(if2)
  );

  // {PC, PCCond, PCBack, IR, MDR, Reg, Mem, LeMem}
  logic [7:0] en1;
  assign en1 = {if1.oEscrevePC, if1.oEscrevePCCondicional, if1.oEscrevePCBack,
                if1.oEscreveIR, if1.oEscreveMDR, if1.oEscreveReg,
                if1.oEscreveMem, if1.oLeMem};

  task automatic reset1();
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
  endtask

  task automatic test_reset();
    if1.iInst = 32'h0;
    if1.iMemReady = 1'b0;
    reset1();
    #1;
    checks++;
    if (if1.oState !== 6'd0) begin
      failures++; $display("FAIL reset_state got=%0d exp=0", if1.oState);
    end
    checks++;
    if (en1 !== 8'b0000_0001) begin
      failures++; $display("FAIL reset_enables got=%b exp=00000001", en1);
    end
    checks++;
    if ({if1.oIouD, if1.oOrigAULA, if1.oOrigBULA, if1.oMemPraReg, if1.oOrigPC,
         if1.oCondBranch, if1.oIllegal} !== 17'd0) begin
      failures++; $display("FAIL reset_selects got nonzero");
    end
    checks++;
    if (if1.oULAControl !== 4'b0010) begin
      failures++; $display("FAIL reset_ula got=%b exp=0010", if1.oULAControl);
    end
  endtask

  task automatic test_add();
    int unsigned exp_st [6] = '{0, 1, 2, 7, 9, 0};
    reset1();
    if1.iInst = 32'h002081B3;
    if1.iMemReady = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (if1.oState !== 6'(exp_st[i])) begin
        failures++; $display("FAIL add_state[%0d] got=%0d exp=%0d", i, if1.oState, exp_st[i]);
      end
      checks++;
      if (if1.oEscreveReg !== (exp_st[i] == 9)) begin
        failures++; $display("FAIL add_reg[%0d] got=%b", i, if1.oEscreveReg);
      end
      if (i == 1) begin
        checks++;
        if ({en1, if1.oOrigAULA, if1.oOrigBULA} !== {8'b1011_0000, 3'd1, 3'd1}) begin
          failures++; $display("FAIL fetch1_ctrl got=%b/%0d/%0d", en1, if1.oOrigAULA, if1.oOrigBULA);
        end
      end
      if (i == 2) begin
        checks++;
        if ({if1.oOrigAULA, if1.oOrigBULA, if1.oULAControl} !== {3'd2, 3'd2, 4'b0010}) begin
          failures++; $display("FAIL decode_ctrl got=%0d/%0d/%b", if1.oOrigAULA, if1.oOrigBULA, if1.oULAControl);
        end
      end
      if (i == 3) begin
        checks++;
        if (if1.oULAControl !== 4'b0010) begin
          failures++; $display("FAIL add_ula got=%b exp=0010", if1.oULAControl);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_wait();
    int unsigned exp_st [10] = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 0};
    logic        rdy    [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    reset1();
    if1.iInst = 32'h0080A283;
    for (int unsigned i = 0; i < 10; i++) begin
      if1.iMemReady = rdy[i];
      #1;
      checks++;
      if (if1.oState !== 6'(exp_st[i])) begin
        failures++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, if1.oState, exp_st[i]);
      end
      checks++;
      if ({if1.oEscreveMDR, if1.oEscreveReg} !== {i == 7, i == 8}) begin
        failures++; $display("FAIL lw_mdr_reg[%0d] got=%b%b", i, if1.oEscreveMDR, if1.oEscreveReg);
      end
      if (exp_st[i] == 4) begin
        checks++;
        if ({if1.oLeMem, if1.oIouD} !== 2'b11) begin
          failures++; $display("FAIL lw_req[%0d] got=%b%b exp=11", i, if1.oLeMem, if1.oIouD);
        end
      end
      if (i == 8) begin
        checks++;
        if (if1.oMemPraReg !== 3'd2) begin
          failures++; $display("FAIL lw_wbsel got=%0d exp=2", if1.oMemPraReg);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store_wait();
    int unsigned exp_st [7] = '{0, 1, 2, 3, 6, 6, 0};
    logic        rdy    [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    reset1();
    if1.iInst = 32'h0020A223;
    for (int unsigned i = 0; i < 7; i++) begin
      if1.iMemReady = rdy[i];
      #1;
      checks++;
      if (if1.oState !== 6'(exp_st[i])) begin
        failures++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, if1.oState, exp_st[i]);
      end
      checks++;
      if ({if1.oEscreveMem, if1.oIouD} !== {2{exp_st[i] == 6}}) begin
        failures++; $display("FAIL sw_mem[%0d] got=%b%b", i, if1.oEscreveMem, if1.oIouD);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] insts [5] = '{32'h402081B3, 32'h4020D193, 32'h0020A1B3, 32'h0050C193, 32'h0020F1B3};
    int unsigned st    [5] = '{7, 8, 7, 8, 7};
    logic [3:0]  op    [5] = '{4'b0110, 4'b1010, 4'b0111, 4'b0011, 4'b0000};
    for (int unsigned k = 0; k < 5; k++) begin
      reset1();
      if1.iInst = insts[k];
      if1.iMemReady = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({if1.oState, if1.oULAControl} !== {6'(st[k]), op[k]}) begin
        failures++; $display("FAIL alu_op[%0d] got st=%0d op=%b exp st=%0d op=%b",
                             k, if1.oState, if1.oULAControl, st[k], op[k]);
      end
      @(negedge clk);
      #1;
      checks++;
      if (if1.oState !== 6'd9) begin
        failures++; $display("FAIL alu_wb[%0d] got=%0d exp=9", k, if1.oState);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] insts [2] = '{32'h00208463, 32'h00209463};
    logic [2:0]  f3    [2] = '{3'b000, 3'b001};
    for (int unsigned k = 0; k < 2; k++) begin
      reset1();
      if1.iInst = insts[k];
      if1.iMemReady = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({if1.oCondBranch, if1.oEscrevePCCondicional} !== 4'b0000) begin
        failures++; $display("FAIL br_decode_cond[%0d] got=%b", k, if1.oCondBranch);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({if1.oState, if1.oEscrevePCCondicional, if1.oOrigPC, if1.oCondBranch, if1.oULAControl, if1.oEscrevePC}
          !== {6'd10, 1'b1, 3'd1, f3[k], 4'b0110, 1'b0}) begin
        failures++; $display("FAIL br_ctrl[%0d] got st=%0d pcc=%b opc=%0d cb=%b ula=%b",
                             k, if1.oState, if1.oEscrevePCCondicional, if1.oOrigPC, if1.oCondBranch, if1.oULAControl);
      end
      @(negedge clk);
      #1;
      checks++;
      if (if1.oState !== 6'd0) begin
        failures++; $display("FAIL br_return[%0d] got=%0d exp=0", k, if1.oState);
      end
    end
  endtask

  task automatic test_jumps();
    int unsigned exp_st [7] = '{0, 0, 0, 1, 2, 12, 0};
    reset1();
    if1.iInst = 32'h008000EF;
    if1.iMemReady = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({if1.oState, if1.oEscreveReg, if1.oEscrevePC, if1.oMemPraReg, if1.oOrigPC}
        !== {6'd11, 1'b1, 1'b1, 3'd1, 3'd1}) begin
      failures++; $display("FAIL jal_ctrl got st=%0d wb=%0d opc=%0d", if1.oState, if1.oMemPraReg, if1.oOrigPC);
    end
    reset1();
    if1.iInst = 32'h000100E7;
    for (int unsigned i = 0; i < 7; i++) begin
      if1.iMemReady = (i >= 2);
      #1;
      checks++;
      if (if1.oState !== 6'(exp_st[i])) begin
        failures++; $display("FAIL jalr_state[%0d] got=%0d exp=%0d", i, if1.oState, exp_st[i]);
      end
      if (i < 3) begin
        checks++;
        if ({if1.oLeMem, if1.oIouD, if1.oEscreveIR} !== 3'b100) begin
          failures++; $display("FAIL fetch_wait[%0d] got=%b exp=100", i, {if1.oLeMem, if1.oIouD, if1.oEscreveIR});
        end
      end
      if (i == 5) begin
        checks++;
        if ({if1.oOrigPC, if1.oMemPraReg, if1.oOrigBULA, if1.oEscrevePC, if1.oEscreveReg}
            !== {3'd2, 3'd1, 3'd2, 1'b1, 1'b1}) begin
          failures++; $display("FAIL jalr_ctrl got opc=%0d wb=%0d b=%0d", if1.oOrigPC, if1.oMemPraReg, if1.oOrigBULA);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lui_auipc();
    logic [31:0] insts [2] = '{32'h123452B7, 32'h00001197};
    int unsigned st    [2] = '{13, 14};
    logic [2:0]  sela  [2] = '{3'd3, 3'd2};
    for (int unsigned k = 0; k < 2; k++) begin
      reset1();
      if1.iInst = insts[k];
      if1.iMemReady = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({if1.oState, if1.oOrigAULA, if1.oOrigBULA, if1.oULAControl}
          !== {6'(st[k]), sela[k], 3'd2, 4'b0010}) begin
        failures++; $display("FAIL upper_ctrl[%0d] got st=%0d a=%0d b=%0d", k, if1.oState, if1.oOrigAULA, if1.oOrigBULA);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({if1.oState, if1.oEscreveReg} !== {6'd9, 1'b1}) begin
        failures++; $display("FAIL upper_wb[%0d] got st=%0d", k, if1.oState);
      end
    end
  endtask

  task automatic test_illegal();
    int unsigned bad = 0;
    reset1();
    if1.iInst = 32'h022081B3;
    if1.iMemReady = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if ({if1.oState, if1.oIllegal} !== {6'd15, 1'b1}) begin
      failures++; $display("FAIL illegal_funct7 got st=%0d ill=%b exp st=15", if1.oState, if1.oIllegal);
    end
    reset1();
    if1.iInst = 32'h0000007F;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({if1.oState, if1.oIllegal} !== {6'd15, 1'b1}) begin
      failures++; $display("FAIL illegal_opcode got st=%0d ill=%b exp st=15", if1.oState, if1.oIllegal);
    end
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if ({if1.oState, if1.oIllegal, en1} !== {6'd15, 1'b1, 8'd0}) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL illegal_sticky got=%0d bad cycles exp=0", bad);
    end
    reset1();
    #1;
    checks++;
    if ({if1.oState, if1.oIllegal} !== 7'd0) begin
      failures++; $display("FAIL illegal_clear got st=%0d ill=%b exp 0/0", if1.oState, if1.oIllegal);
    end
  endtask

  task automatic test_en_itype();
    if2.iInst = 32'h123452B7;
    if2.iMemReady = 1'b1;
    @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (if2.oState !== 6'd2) begin
      failures++; $display("FAIL noitype_decode got=%0d exp=2", if2.oState);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({if2.oState, if2.oIllegal} !== {6'd15, 1'b1}) begin
      failures++; $display("FAIL noitype_lui got st=%0d ill=%b exp st=15", if2.oState, if2.oIllegal);
    end
    rst2 = 1'b1;
  endtask

  task automatic test_reset_mid_lw();
    int unsigned bad = 0;
    reset1();
    if1.iInst = 32'h0080A283;
    if1.iMemReady = 1'b1;
    repeat (4) @(negedge clk);
    if1.iMemReady = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (if1.oState !== 6'd4) begin
      failures++; $display("FAIL midlw_in_lw got=%0d exp=4", if1.oState);
    end
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    #1;
    checks++;
    if ({if1.oState, en1} !== {6'd0, 8'b0000_0001}) begin
      failures++; $display("FAIL midlw_after_reset got st=%0d en=%b exp 0/00000001", if1.oState, en1);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (if1.oEscreveReg !== 1'b0 || if1.oState !== 6'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL midlw_no_write got=%0d bad cycles exp=0", bad);
    end
  endtask

  initial begin
    if2.iInst = 32'h0;
    if2.iMemReady = 1'b0;
    test_reset();
    test_add();
    test_load_wait();
    test_store_wait();
    test_alu_ops();
    test_branch();
    test_jumps();
    test_lui_auipc();
    test_illegal();
    test_en_itype();
    test_reset_mid_lw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
